// File: rtl/ddr_line_bridge.sv
// ddr_line_bridge: turns cache line read/write requests into MIG-style app_*
// commands. One pending request per direction; writes win over reads so a
// read that follows a write returns the new data.
module ddr_line_bridge #(
  parameter int ADDR_W   = 27,
  parameter int DATA_W   = 128,
  parameter int LINE_LSB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  input  logic [ADDR_W-1:0] cache2DDR_rd_addr,
  input  logic              cache2DDR_rd_en,
  output logic              DDR2cache_rd_fin,
  output logic [DATA_W-1:0] DDR2cache_rd_data,
  input  logic [ADDR_W-1:0] cache2DDR_wr_addr,
  input  logic [DATA_W-1:0] cache2DDR_wr_data,
  input  logic              cache2DDR_wr_en,
  output logic              DDR2cache_wr_fin,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid
);

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-LINE_LSB){1'b1}}, {LINE_LSB{1'b0}}};

  typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              rd_en_q, wr_en_q;
  logic              rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              app_en_q, app_en_d;
  logic [2:0]        app_cmd_q, app_cmd_d;
  logic [ADDR_W-1:0] app_addr_q, app_addr_d;
  logic [DATA_W-1:0] wdf_data_q, wdf_data_d;
  logic              wren_q, wren_d;
  logic              rd_fin_q, rd_fin_d, wr_fin_q, wr_fin_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_edge, wr_edge, go_wr, go_rd, cmd_ok, dat_ok, rd_clr, wr_clr;

  assign rd_edge = cache2DDR_rd_en & ~rd_en_q;
  assign wr_edge = cache2DDR_wr_en & ~wr_en_q;
  assign go_wr   = init_calib_complete & wr_pend_q;
  assign go_rd   = init_calib_complete & rd_pend_q & ~wr_pend_q;
  // Each write handshake is done once its valid has dropped or is being taken now.
  assign cmd_ok  = ~app_en_q | app_rdy;
  assign dat_ok  = ~wren_q | app_wdf_rdy;

  // Pending flags: an edge only registers when that direction is free.
  assign rd_pend_d = rd_clr ? 1'b0 : (rd_pend_q | rd_edge);
  assign wr_pend_d = wr_clr ? 1'b0 : (wr_pend_q | wr_edge);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (go_wr) state_d = WR_ISSUE;
                else if (go_rd) state_d = RD_ISSUE;
      WR_ISSUE: if (cmd_ok && dat_ok) state_d = DONE;
      RD_ISSUE: if (app_rdy) state_d = RD_WAIT;
      RD_WAIT:  if (app_rd_data_valid) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of the registered controller/cache outputs.
  always_comb begin
    app_en_d   = app_en_q;
    app_cmd_d  = app_cmd_q;
    app_addr_d = app_addr_q;
    wdf_data_d = wdf_data_q;
    wren_d     = wren_q;
    rd_data_d  = rd_data_q;
    rd_fin_d   = 1'b0;
    wr_fin_d   = 1'b0;
    rd_clr     = 1'b0;
    wr_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_wr) begin
          app_en_d   = 1'b1;
          app_cmd_d  = CMD_WR;
          app_addr_d = wr_addr_q;
          wdf_data_d = wr_data_q;
          wren_d     = 1'b1;
        end else if (go_rd) begin
          app_en_d   = 1'b1;
          app_cmd_d  = CMD_RD;
          app_addr_d = rd_addr_q;
        end
      end
      WR_ISSUE: begin
        if (app_en_q && app_rdy)   app_en_d = 1'b0;
        if (wren_q && app_wdf_rdy) wren_d   = 1'b0;
        if (cmd_ok && dat_ok) begin
          wr_fin_d = 1'b1;
          wr_clr   = 1'b1;
        end
      end
      RD_ISSUE: if (app_rdy) app_en_d = 1'b0;
      RD_WAIT: begin
        if (app_rd_data_valid) begin
          rd_data_d = app_rd_data;
          rd_fin_d  = 1'b1;
          rd_clr    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Request capture, pending flags and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      wr_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      app_en_q   <= 1'b0;
      app_cmd_q  <= '0;
      app_addr_q <= '0;
      wdf_data_q <= '0;
      wren_q     <= 1'b0;
      rd_fin_q   <= 1'b0;
      wr_fin_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_en_q    <= cache2DDR_rd_en;
      wr_en_q    <= cache2DDR_wr_en;
      rd_pend_q  <= rd_pend_d;
      wr_pend_q  <= wr_pend_d;
      if (rd_edge && !rd_pend_q) rd_addr_q <= cache2DDR_rd_addr & LINE_MASK;
      if (wr_edge && !wr_pend_q) begin
        wr_addr_q <= cache2DDR_wr_addr & LINE_MASK;
        wr_data_q <= cache2DDR_wr_data;
      end
      app_en_q   <= app_en_d;
      app_cmd_q  <= app_cmd_d;
      app_addr_q <= app_addr_d;
      wdf_data_q <= wdf_data_d;
      wren_q     <= wren_d;
      rd_fin_q   <= rd_fin_d;
      wr_fin_q   <= wr_fin_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign app_en            = app_en_q;
  assign app_cmd           = app_cmd_q;
  assign app_addr          = app_addr_q;
  assign app_wdf_data      = wdf_data_q;
  assign app_wdf_wren      = wren_q;
  assign app_wdf_end       = wren_q;
  assign DDR2cache_rd_fin  = rd_fin_q;
  assign DDR2cache_wr_fin  = wr_fin_q;
  assign DDR2cache_rd_data = rd_data_q;

endmodule

// File: tb/tb_ddr_line_bridge.sv
// Scoreboard bench for ddr_line_bridge: stimulus pushes expected commands,
// write beats and fin events; a forked monitor pops and compares them.
module tb_ddr_line_bridge;
  localparam int AW = 27;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          calib;
  logic [AW-1:0] rd_addr, wr_addr, app_addr;
  logic          rd_en, wr_en, rd_fin, wr_fin;
  logic [DW-1:0] rd_data, wr_data, wdf_data, app_rd_data;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy, wdf_wren, wdf_end, wdf_rdy, rd_valid;

  ddr_line_bridge dut (
    .clk(clk), .rst(rst), .init_calib_complete(calib),
    .cache2DDR_rd_addr(rd_addr), .cache2DDR_rd_en(rd_en),
    .DDR2cache_rd_fin(rd_fin), .DDR2cache_rd_data(rd_data),
    .cache2DDR_wr_addr(wr_addr), .cache2DDR_wr_data(wr_data),
    .cache2DDR_wr_en(wr_en), .DDR2cache_wr_fin(wr_fin),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(wdf_data), .app_wdf_wren(wdf_wren), .app_wdf_end(wdf_end),
    .app_wdf_rdy(wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] cmd; logic [AW-1:0] addr; } cmd_t;
  typedef struct { bit is_rd; logic [DW-1:0] data; } fin_t;

  cmd_t          cmd_q[$];
  logic [DW-1:0] wdf_q[$];
  fin_t          fin_q[$];
  int checks = 0, errors = 0;
  int en_cnt = 0, wren_cnt = 0, iss_cnt = 0;

  localparam logic [DW-1:0] D_WR  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [DW-1:0] D_RD1 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [DW-1:0] D_RD3 = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
  localparam logic [DW-1:0] D_W4  = 128'hA5A5A5A5_00000000_5A5A5A5A_FFFF0000;
  localparam logic [DW-1:0] D_RD4 = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
  localparam logic [DW-1:0] D_W5  = 128'hCAFEF00D_CAFEF00D_00C0FFEE_00C0FFEE;
  localparam logic [DW-1:0] D_RD6 = 128'h600DF00D_BAADC0DE_00000006_66666666;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    cmd_t e;
    e.cmd = c; e.addr = a;
    cmd_q.push_back(e);
  endtask

  task automatic push_fin(input bit is_rd, input logic [DW-1:0] d);
    fin_t f;
    f.is_rd = is_rd; f.data = d;
    fin_q.push_back(f);
  endtask

  // Pops expectations whenever the DUT completes a handshake or pulses a fin.
  task automatic monitor();
    cmd_t c;
    fin_t f;
    logic [DW-1:0] w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (app_en) en_cnt++;
        if (wdf_wren) wren_cnt++;
        if (app_en && app_rdy) begin
          iss_cnt++;
          if (cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
          else begin
            c = cmd_q.pop_front();
            chk("app_cmd", DW'(app_cmd), DW'(c.cmd));
            chk("app_addr", DW'(app_addr), DW'(c.addr));
          end
        end
        if (wdf_wren && wdf_rdy) begin
          if (wdf_q.size() == 0) chk("wdf_unexpected", 1, 0);
          else begin
            w = wdf_q.pop_front();
            chk("wdf_data", wdf_data, w);
            chk("wdf_end", DW'(wdf_end), 1);
          end
        end
        if (rd_fin || wr_fin) begin
          if (fin_q.size() == 0) chk("fin_unexpected", {rd_fin, wr_fin}, 0);
          else begin
            f = fin_q.pop_front();
            chk("fin_kind", DW'(rd_fin), DW'(f.is_rd));
            chk("fin_single", DW'(rd_fin & wr_fin), 0);
            if (f.is_rd) chk("rd_data", rd_data, f.data);
          end
        end
      end
    end
  endtask

  // Controller read responder: waits for the read acceptance, then returns
  // data n cycles later; rd_fin must follow the valid cycle directly.
  task automatic rd_respond(input logic [DW-1:0] d, input int n);
    int k = 0;
    while (!(app_en && app_rdy && app_cmd == 3'b001) && k < 100) begin tick(); k++; end
    if (k >= 100) chk("rd_accept_timeout", 1, 0);
    else begin
      tick();
      repeat (n - 1) tick();
      app_rd_data = d; rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0; app_rd_data = '0;
      chk("rd_fin_after_valid", DW'(rd_fin), 1);
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (fin_q.size() != 0 && k < 200) begin tick(); k++; end
    chk(nm, fin_q.size(), 0);
    tick(); tick();
  endtask

  task automatic wait_en(input string nm);
    int k = 0;
    while (!app_en && k < 50) begin tick(); k++; end
    if (k >= 50) chk(nm, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, bw, bi;
    rst = 1'b1; calib = 1'b1;
    rd_addr = '0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; wr_en = 1'b0;
    app_rdy = 1'b0; wdf_rdy = 1'b0; rd_valid = 1'b0; app_rd_data = '0;
    fork monitor(); join_none
    repeat (3) tick();
    chk("rst_app_en", DW'(app_en), 0);
    chk("rst_wren", DW'({wdf_wren, wdf_end}), 0);
    chk("rst_fins", DW'({rd_fin, wr_fin}), 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();

    // Write 0x000ABCD, both readies high: wr_fin three cycles after the edge.
    app_rdy = 1'b1; wdf_rdy = 1'b1;
    wr_addr = 27'h000ABCD; wr_data = D_WR;
    push_cmd(3'b000, 27'h000ABC0); wdf_q.push_back(D_WR); push_fin(0, '0);
    wr_en = 1'b1;
    tick();
    tick();
    chk("wr_app_en", DW'(app_en), 1);
    chk("wr_wdf_end", DW'(wdf_end), 1);
    tick();
    chk("wr_fin_lat3", DW'(wr_fin), 1);
    tick();
    chk("wr_fin_pulse", DW'(wr_fin), 0);
    wr_en = 1'b0;
    drain("wr_drain");

    // Reset in the middle of a read that is stuck waiting for app_rdy.
    app_rdy = 1'b0;
    rd_addr = 27'h0000100; rd_en = 1'b1;
    wait_en("midrd_en_timeout");
    rst = 1'b1; rd_en = 1'b0;
    tick();
    chk("midrst_app_en", DW'(app_en), 0);
    chk("midrst_cmd_addr", DW'({app_cmd, app_addr}), 0);
    chk("midrst_wdf", wdf_data, 0);
    tick(); tick();
    rst = 1'b0;
    b = en_cnt;
    app_rdy = 1'b1;
    repeat (8) tick();
    chk("midrst_no_reissue", en_cnt - b, 0);
    rd_addr = 27'h0001230;
    push_cmd(3'b001, 27'h0001230); push_fin(1, D_RD1);
    rd_en = 1'b1;
    rd_respond(D_RD1, 2);
    rd_en = 1'b0;
    drain("rd1_drain");

    // Read 0x7FFFFFF with app_rdy low for five cycles, data 10 cycles later.
    app_rdy = 1'b0;
    rd_addr = 27'h7FFFFFF;
    push_cmd(3'b001, 27'h7FFFFF0); push_fin(1, D_RD3);
    b = en_cnt;
    rd_en = 1'b1;
    wait_en("rd3_en_timeout");
    repeat (5) tick();
    app_rdy = 1'b1;
    rd_respond(D_RD3, 10);
    chk("rd3_en_cycles", en_cnt - b, 6);
    rd_en = 1'b0;
    drain("rd3_drain");

    // Write with the data FIFO stalled four cycles.
    wdf_rdy = 1'b0;
    wr_addr = 27'h0000317; wr_data = D_W5;
    push_cmd(3'b000, 27'h0000310); wdf_q.push_back(D_W5); push_fin(0, '0);
    bw = wren_cnt;
    wr_en = 1'b1;
    wait_en("w5_en_timeout");
    tick();
    chk("w5_app_en_drop", DW'(app_en), 0);
    chk("w5_wren_held", DW'(wdf_wren), 1);
    tick(); tick(); tick();
    chk("w5_fin_early", DW'(wr_fin), 0);
    wdf_rdy = 1'b1;
    tick();
    chk("w5_fin", DW'(wr_fin), 1);
    chk("w5_wren_drop", DW'(wdf_wren), 0);
    chk("w5_wren_cycles", wren_cnt - bw, 5);
    wr_en = 1'b0;
    drain("w5_drain");
    chk("rd_data_held", rd_data, D_RD3);

    // Read and write edges in the same cycle: write goes first.
    wr_addr = 27'h0000040; wr_data = D_W4; rd_addr = 27'h0000085;
    push_cmd(3'b000, 27'h0000040); push_cmd(3'b001, 27'h0000080);
    wdf_q.push_back(D_W4); push_fin(0, '0); push_fin(1, D_RD4);
    wr_en = 1'b1; rd_en = 1'b1;
    rd_respond(D_RD4, 1);
    wr_en = 1'b0; rd_en = 1'b0;
    drain("both_drain");

    // Stray read-data valid while idle must be ignored.
    app_rd_data = {DW{1'b1}}; rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0; app_rd_data = '0;
    tick();
    chk("stray_valid_ignored", rd_data, D_RD4);

    // Calibration gate, and a long rd_en level producing exactly one read.
    calib = 1'b0;
    rd_addr = 27'h0000200;
    push_cmd(3'b001, 27'h0000200); push_fin(1, D_RD6);
    b = en_cnt; bi = iss_cnt;
    rd_en = 1'b1;
    repeat (10) tick();
    chk("calib_block", en_cnt - b, 0);
    calib = 1'b1;
    rd_respond(D_RD6, 3);
    repeat (12) tick();
    chk("one_read", iss_cnt - bi, 1);
    rd_en = 1'b0;
    drain("rd6_drain");

    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("wdf_q_empty", wdf_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
